int_ascii_tx: RTL and testbench
===============================

Name: int_ascii_tx

Overview:
Binary-to-ASCII encoder for the RPN calculator's character stream. Accepts one signed two's-complement integer on a stb/ack word interface. Emits its decimal text, most significant digit first, as ASCII characters on the same stb/ack character protocol the alu consumes. It sits between a result register and the alu's input port or the display/UART path.

Parameters:
WIDTH, 16, bit width of the signed input value
DIGITS, 5, digit buffer depth; must be at least the decimal digit count of 2^(WIDTH-1); checked at elaboration

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous reset, active-low (reset=0 clears all state)
in_stb  input  1  in_data valid; producer holds it until accepted
in_data  input  WIDTH  signed two's-complement value
in_ack  output  1  ready to accept a value
out_stb  output  1  out_char valid
out_char  output  8  ASCII character, bit order [0:7] as elsewhere in the calculator
out_ack  input  1  consumer accepts out_char

Behaviour:
- Transfer rule, both ports: one transfer per rising edge where stb=1 and ack=1. A stb without ack holds: out_char stays stable and out_stb stays high until out_ack is seen.
- Reset values: out_stb=0, out_char=8'h00, state=IDLE, buffer empty. in_ack is combinational (state==IDLE), so it reads 1 during and after reset.
- States:
  - IDLE: on in_stb&in_ack, latch sign=in_data[WIDTH-1]. Latch magnitude = |in_data| in WIDTH+1 bits, so -2^(WIDTH-1) is exact. Go to CONV.
  - CONV: each cycle, push magnitude%10 into the digit LIFO and set magnitude=magnitude/10. Leave when the new quotient is 0; at least one digit is pushed, so 0 gives "0". Next state is SIGN if negative, else DIGIT. CONV takes d cycles for a d-digit result.
  - SIGN: out_stb=1, out_char=8'h2d ('-'). On out_ack, go to DIGIT.
  - DIGIT: out_stb=1, out_char=8'h30+top digit. On out_ack, pop. If the LIFO becomes empty, go to TERM when the feature is enabled, else IDLE.
  - TERM: described under Optional Feature.
- Latency: accept on edge N; first out_stb=1 after edge N+d. Back-to-back characters need no idle cycle when out_ack is held high.
- out_stb drops to 0 on the edge that accepts the last character, unless a next character follows.
- A new value is accepted no earlier than the edge after the last character transfer (in_ack=1 only in IDLE).
- in_stb asserted outside IDLE is ignored, not queued.
- Reset mid-operation: all state is cleared immediately and asynchronously, out_stb=0, and the partial string is abandoned. The consumer sees no further characters of that value.
- LIFO overflow cannot occur when DIGITS is legal.

Optional Feature:
Macro INT_ASCII_TX_TERM_EN.
- Defined: after the last digit, state TERM emits out_char=8'h3d ('=') with normal handshake, then returns to IDLE. Each value then forms a complete "number =" token for the alu.
- Undefined: the TERM state and its logic are absent; DIGIT returns directly to IDLE.

Decomposition:
- Shared package rpn_pkg: ASCII constants NUM_0, MINUS_SGN, PLUS_SGN, MUL_SGN, DIV_SGN, EQU_SGN, BRACKET_OPEN, BRACKET_CLOSE, plus the tx_state_t enum (IDLE, CONV, SIGN, DIGIT, TERM).
- One sub-module, digit_lifo: DIGITS x 4-bit stack with push, pop, empty, top, and asynchronous active-low reset.

Test Plan:
- in_data=21, out_ack held 1 -> out_char 8'h32, 8'h31 on consecutive cycles; with TERM_EN, then 8'h3d; then in_ack=1.
- in_data=-7 -> 8'h2d, 8'h37; first out_stb exactly 1 edge after accept (d=1).
- in_data=0 -> single 8'h30; in_data=-32768 (WIDTH=16) -> 8'h2d, 33, 32, 37, 36, 38.
- out_ack low for 5 cycles during the second digit of 123 -> out_stb high and out_char=8'h32 stable throughout; sequence completes unchanged after release.
- reset pulsed low during the DIGIT state of 9876 -> out_stb=0 immediately (asynchronously); no further chars; in_ack=1; next value 5 emits 8'h35 only.
- in_stb pulsed while busy -> ignored; emitted characters match the first value only.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator character stream:
// ASCII token constants, the integer-to-ASCII transmitter state encoding,
// and small helpers used by the encoder.
package rpn_pkg;

    // ASCII characters understood by the alu input port
    localparam logic [7:0] NUM_0         = 8'h30;
    localparam logic [7:0] MINUS_SGN     = 8'h2d;
    localparam logic [7:0] PLUS_SGN      = 8'h2b;
    localparam logic [7:0] MUL_SGN       = 8'h2a;
    localparam logic [7:0] DIV_SGN       = 8'h2f;
    localparam logic [7:0] EQU_SGN       = 8'h3d;
    localparam logic [7:0] BRACKET_OPEN  = 8'h28;
    localparam logic [7:0] BRACKET_CLOSE = 8'h29;

    // Transmitter states; TERM is only reachable when the terminator is built in
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        SIGN  = 3'd2,
        DIGIT = 3'd3,
        TERM  = 3'd4
    } tx_state_t;

    // Number of decimal digits needed to print 2^(w-1), the largest magnitude
    // a w-bit two's-complement value can have.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = 64'd1 << (w - 1);
        n = 1;
        v = v / 64'd10;
        while (v != 64'd0) begin
            n = n + 1;
            v = v / 64'd10;
        end
        return n;
    endfunction

    // ASCII code of a single decimal digit
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return NUM_0 + {4'b0000, d};
    endfunction

endpackage

// File: rtl/digit_lifo.sv
// Small last-in first-out store of 4-bit decimal digits.
// Besides the top entry it exposes the entry directly below the top, so the
// owner can register the following character on the same edge it pops.
module digit_lifo #(
    parameter int DIGITS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop,
    output logic       empty,
    output logic       last,
    output logic [3:0] top,
    output logic [3:0] next
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [CW-1:0] count_r;
    logic [3:0]    mem_r [DIGITS];

    // Stack storage and fill level; push wins over pop, both are guarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CW'(0);
            for (int i = 0; i < DIGITS; i++) begin
                mem_r[i] <= 4'd0;
            end
        end else begin
            if (push && (count_r != CW'(DIGITS))) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (CW'(i) == count_r) begin
                        mem_r[i] <= push_data;
                    end
                end
                count_r <= count_r + CW'(1);
            end else if (pop && (count_r != CW'(0))) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Status flags and read-out of the two topmost entries
    always_comb begin
        empty = (count_r == CW'(0));
        last  = (count_r == CW'(1));
        top   = 4'd0;
        next  = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (CW'(i + 1) == count_r) begin
                top = mem_r[i];
            end else begin
                top = top;
            end
            if (CW'(i + 2) == count_r) begin
                next = mem_r[i];
            end else begin
                next = next;
            end
        end
    end

endmodule

// File: rtl/int_ascii_tx.sv
// Signed integer to decimal ASCII encoder for the RPN calculator stream.
// One word is accepted on the in_stb/in_ack port, converted digit by digit
// (least significant first into a LIFO) and then sent most significant digit
// first on the out_stb/out_ack character port, preceded by '-' if negative.
// Build option INT_ASCII_TX_TERM_EN appends '=' after the last digit so each
// value forms a complete "number =" token for the alu.
module int_ascii_tx
    import rpn_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_stb,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ack,
    output logic             out_stb,
    output logic [0:7]       out_char,
    input  logic             out_ack
);

    // The digit buffer must hold every digit of the most negative value
    if (DIGITS < dec_digits(WIDTH)) begin : g_digits_check
        $error("int_ascii_tx: DIGITS too small for WIDTH");
    end

    localparam logic [WIDTH:0] TEN = (WIDTH + 1)'(10);

    tx_state_t      state_r;
    logic           sign_r;
    logic [WIDTH:0] mag_r;
    logic           out_stb_r;
    logic [7:0]     out_char_r;

    logic [WIDTH:0] ext_s;
    logic [WIDTH:0] abs_s;
    logic [WIDTH:0] quot_s;
    logic [3:0]     digit_s;
    logic           push_s;
    logic           pop_s;
    logic           lifo_empty_s;
    logic           lifo_last_s;
    logic [3:0]     lifo_top_s;
    logic [3:0]     lifo_next_s;

    // Magnitude in one extra bit so the most negative input stays exact,
    // plus one decimal division step of the working magnitude
    always_comb begin
        ext_s = {in_data[WIDTH-1], in_data};
        if (in_data[WIDTH-1]) begin
            abs_s = (~ext_s) + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            abs_s = ext_s;
        end
        quot_s  = mag_r / TEN;
        digit_s = 4'(mag_r - (quot_s * TEN));
    end

    // Buffer control: one push per conversion cycle, pop on each digit transfer
    always_comb begin
        push_s = (state_r == CONV);
        pop_s  = (state_r == DIGIT) && out_stb_r && out_ack;
    end

    digit_lifo #(
        .DIGITS (DIGITS)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .push_data (digit_s),
        .pop       (pop_s),
        .empty     (lifo_empty_s),
        .last      (lifo_last_s),
        .top       (lifo_top_s),
        .next      (lifo_next_s)
    );

    // Sequencer: accept, convert, then emit sign, digits and optional terminator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            sign_r     <= 1'b0;
            mag_r      <= '0;
            out_stb_r  <= 1'b0;
            out_char_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_ack is high here, so in_stb alone is a transfer
                    if (in_stb) begin
                        sign_r  <= in_data[WIDTH-1];
                        mag_r   <= abs_s;
                        state_r <= CONV;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONV: begin
                    mag_r <= quot_s;
                    // The digit pushed on this edge becomes the top entry
                    if (quot_s == '0) begin
                        out_stb_r <= 1'b1;
                        if (sign_r) begin
                            out_char_r <= MINUS_SGN;
                            state_r    <= SIGN;
                        end else begin
                            out_char_r <= digit_char(digit_s);
                            state_r    <= DIGIT;
                        end
                    end else begin
                        state_r <= CONV;
                    end
                end
                SIGN: begin
                    if (out_ack) begin
                        out_char_r <= digit_char(lifo_top_s);
                        state_r    <= DIGIT;
                    end else begin
                        state_r <= SIGN;
                    end
                end
                DIGIT: begin
                    if (out_ack) begin
                        if (lifo_last_s || lifo_empty_s) begin
`ifdef INT_ASCII_TX_TERM_EN
                            out_char_r <= EQU_SGN;
                            state_r    <= TERM;
`else
                            out_stb_r  <= 1'b0;
                            state_r    <= IDLE;
`endif
                        end else begin
                            out_char_r <= digit_char(lifo_next_s);
                            state_r    <= DIGIT;
                        end
                    end else begin
                        state_r <= DIGIT;
                    end
                end
`ifdef INT_ASCII_TX_TERM_EN
                TERM: begin
                    if (out_ack) begin
                        out_stb_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= TERM;
                    end
                end
`endif
                default: begin
                    out_stb_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Output port drive; in_ack reflects the idle state directly
    always_comb begin
        in_ack   = (state_r == IDLE);
        out_stb  = out_stb_r;
        out_char = out_char_r;
    end

endmodule

// File: tb/tb_int_ascii_tx.sv
// Self-checking bench for int_ascii_tx. A reference model turns every accepted
// value into its expected character string with $sformatf and a queue; a
// monitor compares the DUT against it on each falling edge. Directed tests add
// literal string expectations that pin the model.
module tb_int_ascii_tx;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_stb = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ack;
    logic             out_stb;
    logic [0:7]       out_char;
    logic             out_ack = 1'b1;

    int    checks = 0;
    int    errors = 0;
    byte   exp_q[$];
    string got_s = "";
    string term_s = "";
    int    lat_cnt = 0;
    int    exp_digits = 0;
    bit    started = 1'b0;

    int_ascii_tx #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_stb   (in_stb),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_stb  (out_stb),
        .out_char (out_char),
        .out_ack  (out_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference model and per-cycle comparison
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("in_ack", in_ack === (exp_q.size() == 0),
                  $sformatf("in_ack=%b expected %b", in_ack, exp_q.size() == 0));
            if (exp_q.size() == 0) begin
                check("no_stray_char", out_stb === 1'b0,
                      $sformatf("out_stb=%b out_char=%h expected out_stb=0", out_stb, out_char));
            end else begin
                if (!started) begin
                    if (out_stb === 1'b1) begin
                        started = 1'b1;
                        check("latency", lat_cnt == exp_digits,
                              $sformatf("first out_stb after %0d cycles expected %0d", lat_cnt, exp_digits));
                    end else begin
                        lat_cnt++;
                        if (lat_cnt > exp_digits) begin
                            check("latency_overrun", 1'b0,
                                  $sformatf("no out_stb after %0d cycles expected %0d", lat_cnt, exp_digits));
                            started = 1'b1;
                        end
                    end
                end
                if (started) begin
                    check("char", out_stb === 1'b1 && out_char === exp_q[0],
                          $sformatf("out_stb=%b out_char=%h expected 1/%h", out_stb, out_char, exp_q[0]));
                    if (out_stb === 1'b1 && out_ack === 1'b1) begin
                        got_s = $sformatf("%s%c", got_s, out_char);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) started = 1'b0;
                    end
                end
            end
            if (in_stb === 1'b1 && in_ack === 1'b1) begin
                string s;
                s = $sformatf("%0d", $signed(in_data));
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
                if (term_s.len() > 0) exp_q.push_back(8'h3d);
                exp_digits = s.len() - (in_data[WIDTH-1] ? 1 : 0);
                lat_cnt = 0;
                started = 1'b0;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        int n;
        in_data = v;
        in_stb  = 1'b1;
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("accept_timeout", 1'b0, "in_ack never rose, expected 1");
        @(posedge clk); #1;
        in_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(exp_q.size() == 0 && out_stb === 1'b0 && in_ack === 1'b1) && n < 300);
        if (n >= 300) check("idle_timeout", 1'b0, "DUT never returned to idle");
    endtask

    task automatic wait_chars(input int k);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (got_s.len() < k && n < 100);
        if (n >= 100) check("char_timeout", 1'b0, $sformatf("only %0d chars, expected %0d", got_s.len(), k));
    endtask

    task automatic check_str(input string name, input string want);
        check(name, got_s == want, $sformatf("got \"%s\" expected \"%s\"", got_s, want));
    endtask

    task automatic run_value(input logic [WIDTH-1:0] v, input string name, input string want);
        got_s = "";
        send(v);
        wait_idle();
        check_str(name, {want, term_s});
    endtask

    initial begin
`ifdef INT_ASCII_TX_TERM_EN
        term_s = "=";
`endif
        // Reset state
        #12;
        check("reset_stb", out_stb === 1'b0, $sformatf("out_stb=%b expected 0", out_stb));
        check("reset_char", out_char === 8'h00, $sformatf("out_char=%h expected 00", out_char));
        check("reset_ack", in_ack === 1'b1, $sformatf("in_ack=%b expected 1", in_ack));
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;

        // Main function with ack held high
        run_value(16'd21, "str_21", "21");
        run_value(-16'sd7, "str_m7", "-7");
        run_value(16'd0, "str_0", "0");
        run_value(16'h8000, "str_min", "-32768");
        run_value(16'd32767, "str_max", "32767");

        // Consumer stall during the second digit of 123
        got_s = "";
        send(16'd123);
        wait_chars(1);
        #1 out_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", out_stb === 1'b1 && out_char === 8'h32,
                  $sformatf("out_stb=%b out_char=%h expected 1/32", out_stb, out_char));
        end
        @(posedge clk); #1;
        out_ack = 1'b1;
        wait_idle();
        check_str("str_123", {"123", term_s});

        // Input pulsed while busy is ignored
        got_s = "";
        send(16'd45);
        in_data = 16'd99;
        in_stb  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_stb = 1'b0;
        wait_idle();
        check_str("str_busy", {"45", term_s});

        // Asynchronous reset in the middle of 9876
        got_s = "";
        send(16'd9876);
        wait_chars(2);
        #3 reset = 1'b0;
        exp_q.delete();
        started = 1'b0;
        #1;
        check("async_rst_stb", out_stb === 1'b0, $sformatf("out_stb=%b expected 0", out_stb));
        check("async_rst_ack", in_ack === 1'b1, $sformatf("in_ack=%b expected 1", in_ack));
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_str("str_abandon", "98");
        run_value(16'd5, "str_5", "5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
